// File: rtl/tbus_arbiter_if.sv
// Bundle of requester-side and tbus-side signals around the tbus arbiter.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface tbus_arbiter_if #(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int OPTYPE_WIDTH = 2
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0]   req_index;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_write_data;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_write_mask;
    logic [NUM_REQ*OPTYPE_WIDTH-1:0] req_operation_type;
    logic [NUM_REQ-1:0]              req_flush;
    logic [NUM_REQ-1:0]              resp_done;
    logic [DATA_WIDTH-1:0]           resp_read_data;
    logic                            tbus_index_valid;
    logic                            tbus_index_ready;
    logic [ADDR_WIDTH-1:0]           tbus_index;
    logic [DATA_WIDTH-1:0]           tbus_write_data;
    logic [DATA_WIDTH-1:0]           tbus_write_mask;
    logic [OPTYPE_WIDTH-1:0]         tbus_operation_type;
    logic [DATA_WIDTH-1:0]           tbus_read_data;
    logic                            tbus_operation_done;
    logic                            arb_busy;

    // valid/ready: a transfer happens in any cycle where valid and ready are both high.
    // Valid does not wait for ready. The payload stays stable while valid is high and not yet accepted.
    modport slave (
        input  req_valid, req_index, req_write_data, req_write_mask,
               req_operation_type, req_flush,
               tbus_index_ready, tbus_read_data, tbus_operation_done,
        output req_ready, resp_done, resp_read_data,
               tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask,
               tbus_operation_type, arb_busy
    );

    modport master (
        output req_valid, req_index, req_write_data, req_write_mask,
               req_operation_type, req_flush,
               tbus_index_ready, tbus_read_data, tbus_operation_done,
        input  req_ready, resp_done, resp_read_data,
               tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask,
               tbus_operation_type, arb_busy
    );
endinterface

// File: rtl/tbus_arbiter.sv
// Round-robin arbiter that shares one tbus channel among NUM_REQ requesters.
// The grant is held from request through operation done, and the completion is routed back to the owner.
module tbus_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int OPTYPE_WIDTH = 2
) (
    input  logic          clock,
    input  logic          reset,
    tbus_arbiter_if.slave bus,
    output logic [1:0]    dbg_state_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] winner, grant_next;
    logic [NUM_REQ-1:0] eligible;
    logic             win_found, grant_live, fire;
    int unsigned      cand, gsel;

    assign eligible   = bus.req_valid & ~bus.req_flush;
    assign grant_live = eligible[grant_q];
    assign fire       = (state_q == S_REQ) && grant_live && bus.tbus_index_ready;
    assign grant_next = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
    assign gsel       = 32'(grant_q);
    assign dbg_state_o = state_q;

    // The search starts at rr_ptr and wraps, so the last owner moves to the back of the line.
    always_comb begin
        win_found = 1'b0;
        winner    = rr_ptr_q;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_ptr_q) + 32'(k);
            if (cand >= 32'(NUM_REQ)) cand = cand - 32'(NUM_REQ);
            if (!win_found && eligible[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                winner    = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d = winner;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!grant_live) begin
                    state_d = S_IDLE;
                end else if (fire) begin
                    if (bus.tbus_operation_done) begin
                        rr_ptr_d = grant_next;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.tbus_operation_done) begin
                    rr_ptr_d = grant_next;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready           = '0;
        bus.resp_done           = '0;
        bus.resp_read_data      = bus.tbus_read_data;
        bus.tbus_index_valid    = 1'b0;
        bus.tbus_index          = '0;
        bus.tbus_write_data     = '0;
        bus.tbus_write_mask     = '0;
        bus.tbus_operation_type = '0;
        bus.arb_busy            = (state_q != S_IDLE);
        case (state_q)
            S_REQ: begin
                // The live request is muxed straight through. A drop or flush takes valid down in the same cycle.
                bus.tbus_index_valid    = grant_live;
                bus.tbus_index          = bus.req_index[gsel*ADDR_WIDTH +: ADDR_WIDTH];
                bus.tbus_write_data     = bus.req_write_data[gsel*DATA_WIDTH +: DATA_WIDTH];
                bus.tbus_write_mask     = bus.req_write_mask[gsel*DATA_WIDTH +: DATA_WIDTH];
                bus.tbus_operation_type = bus.req_operation_type[gsel*OPTYPE_WIDTH +: OPTYPE_WIDTH];
                bus.req_ready[grant_q]  = grant_live & bus.tbus_index_ready;
                bus.resp_done[grant_q]  = fire & bus.tbus_operation_done;
            end
            S_WAIT: begin
                bus.resp_done[grant_q] = bus.tbus_operation_done & ~bus.req_flush[grant_q];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_tbus_arbiter.sv
// Directed and randomized checks of tbus_arbiter with three requesters.
// A transaction-level round-robin model predicts each grant and completion.
module tb_tbus_arbiter;
    localparam int NR = 3;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int OW = 2;
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;
    int         total = 0;
    int         bad   = 0;

    tbus_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OPTYPE_WIDTH(OW)) bus_if();

    tbus_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OPTYPE_WIDTH(OW)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus_if.slave),
        .dbg_state_o (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [63:0] idx, input logic [63:0] dat,
                           input logic [63:0] msk, input logic [1:0] op);
        bus_if.req_index[i*AW +: AW]          = idx;
        bus_if.req_write_data[i*DW +: DW]     = dat;
        bus_if.req_write_mask[i*DW +: DW]     = msk;
        bus_if.req_operation_type[i*OW +: OW] = op;
    endtask

    task automatic clear_inputs();
        bus_if.req_valid           = '0;
        bus_if.req_flush           = '0;
        bus_if.req_index           = '0;
        bus_if.req_write_data      = '0;
        bus_if.req_write_mask      = '0;
        bus_if.req_operation_type  = '0;
        bus_if.tbus_index_ready    = 1'b0;
        bus_if.tbus_read_data      = '0;
        bus_if.tbus_operation_done = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
    endtask

    // Reference model state: pending requests plus the round-robin pointer.
    bit          pend[NR];
    logic [63:0] p_idx[NR];
    logic [63:0] p_dat[NR];
    logic [63:0] p_msk[NR];
    logic [1:0]  p_op[NR];
    int          ptr;

    initial begin
        int w, dly, c;
        bit sd, fl;
        logic [63:0] rd;

        // Reset values.
        clear_inputs();
        tick();
        chk("rst_valid", 64'(bus_if.tbus_index_valid), 64'd0);
        chk("rst_ready", 64'(bus_if.req_ready), 64'd0);
        chk("rst_done", 64'(bus_if.resp_done), 64'd0);
        chk("rst_busy", 64'(bus_if.arb_busy), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        reset = 1'b0;
        settle();
        chk("post_rst_busy", 64'(bus_if.arb_busy), 64'd0);

        // Single read on port 0.
        set_req(0, 64'h8000_0010, 64'h0, 64'h0, OP_READ);
        bus_if.req_valid = 3'b001;
        settle();
        chk("rd_idle_valid", 64'(bus_if.tbus_index_valid), 64'd0);
        tick();
        bus_if.tbus_index_ready = 1'b1;
        settle();
        chk("rd_req_valid", 64'(bus_if.tbus_index_valid), 64'd1);
        chk("rd_req_index", bus_if.tbus_index, 64'h8000_0010);
        chk("rd_req_ready", 64'(bus_if.req_ready), 64'b001);
        tick();
        bus_if.req_valid = '0;
        bus_if.tbus_index_ready = 1'b0;
        settle();
        chk("rd_wait_valid", 64'(bus_if.tbus_index_valid), 64'd0);
        chk("rd_wait_busy", 64'(bus_if.arb_busy), 64'd1);
        tick();
        bus_if.tbus_operation_done = 1'b1;
        bus_if.tbus_read_data = 64'hDEAD_BEEF;
        settle();
        chk("rd_done", 64'(bus_if.resp_done), 64'b001);
        chk("rd_data", bus_if.resp_read_data, 64'hDEAD_BEEF);
        tick();
        bus_if.tbus_operation_done = 1'b0;
        settle();
        chk("rd_back_idle", 64'(bus_if.arb_busy), 64'd0);

        // Round-robin between ports 0 and 1, both always requesting.
        do_reset();
        set_req(0, 64'h100, 64'h0, 64'h0, OP_READ);
        set_req(1, 64'h200, 64'h0, 64'h0, OP_READ);
        bus_if.req_valid = 3'b011;
        for (int t = 0; t < 4; t++) begin
            tick();
            bus_if.tbus_index_ready = 1'b1;
            settle();
            chk("rr_grant", 64'(bus_if.req_ready), (t % 2 == 0) ? 64'b001 : 64'b010);
            tick();
            bus_if.tbus_index_ready = 1'b0;
            bus_if.tbus_operation_done = 1'b1;
            settle();
            chk("rr_done", 64'(bus_if.resp_done), (t % 2 == 0) ? 64'b001 : 64'b010);
            tick();
            bus_if.tbus_operation_done = 1'b0;
            settle();
        end
        bus_if.req_valid = '0;

        // Backpressure on a port 1 write.
        do_reset();
        set_req(1, 64'h4000_0040, 64'h1234_5678, 64'hFF00, OP_WRITE);
        bus_if.req_valid = 3'b010;
        tick();
        for (int d = 0; d < 4; d++) begin
            settle();
            chk("bp_valid", 64'(bus_if.tbus_index_valid), 64'd1);
            chk("bp_index", bus_if.tbus_index, 64'h4000_0040);
            chk("bp_mask", bus_if.tbus_write_mask, 64'hFF00);
            chk("bp_ready_low", 64'(bus_if.req_ready), 64'd0);
            tick();
        end
        bus_if.tbus_index_ready = 1'b1;
        settle();
        chk("bp_accept", 64'(bus_if.req_ready), 64'b010);
        chk("bp_op", 64'(bus_if.tbus_operation_type), 64'(OP_WRITE));
        chk("bp_wdata", bus_if.tbus_write_data, 64'h1234_5678);
        tick();
        bus_if.req_valid = '0;
        bus_if.tbus_index_ready = 1'b0;
        bus_if.tbus_operation_done = 1'b1;
        settle();
        chk("bp_done", 64'(bus_if.resp_done), 64'b010);
        tick();
        bus_if.tbus_operation_done = 1'b0;

        // Fire and done in the same cycle, then the pointer must favour port 1.
        do_reset();
        set_req(0, 64'h10, 64'h0, 64'h0, OP_READ);
        set_req(1, 64'h20, 64'h0, 64'h0, OP_READ);
        bus_if.req_valid = 3'b001;
        tick();
        bus_if.tbus_index_ready = 1'b1;
        bus_if.tbus_operation_done = 1'b1;
        settle();
        chk("same_done", 64'(bus_if.resp_done), 64'b001);
        tick();
        bus_if.tbus_index_ready = 1'b0;
        bus_if.tbus_operation_done = 1'b0;
        bus_if.req_valid = 3'b011;
        settle();
        chk("same_idle", 64'(bus_if.arb_busy), 64'd0);
        tick();
        bus_if.tbus_index_ready = 1'b1;
        settle();
        chk("same_ptr_adv", 64'(bus_if.req_ready), 64'b010);
        tick();
        bus_if.req_valid = '0;
        bus_if.tbus_index_ready = 1'b0;
        bus_if.tbus_operation_done = 1'b1;
        tick();
        bus_if.tbus_operation_done = 1'b0;

        // Flush while waiting for done.
        do_reset();
        set_req(0, 64'h30, 64'h0, 64'h0, OP_READ);
        bus_if.req_valid = 3'b001;
        tick();
        bus_if.tbus_index_ready = 1'b1;
        tick();
        bus_if.tbus_index_ready = 1'b0;
        bus_if.req_valid = '0;
        bus_if.req_flush = 3'b001;
        settle();
        chk("flw_busy", 64'(bus_if.arb_busy), 64'd1);
        tick();
        bus_if.tbus_operation_done = 1'b1;
        settle();
        chk("flw_no_done", 64'(bus_if.resp_done), 64'd0);
        tick();
        bus_if.tbus_operation_done = 1'b0;
        bus_if.req_flush = '0;
        settle();
        chk("flw_idle", 64'(bus_if.arb_busy), 64'd0);

        // Flush while the request is being driven.
        bus_if.req_valid = 3'b001;
        tick();
        settle();
        chk("flr_valid_before", 64'(bus_if.tbus_index_valid), 64'd1);
        bus_if.req_flush = 3'b001;
        bus_if.tbus_index_ready = 1'b1;
        settle();
        chk("flr_valid_drop", 64'(bus_if.tbus_index_valid), 64'd0);
        chk("flr_no_ready", 64'(bus_if.req_ready), 64'd0);
        tick();
        bus_if.tbus_index_ready = 1'b0;
        settle();
        chk("flr_idle", 64'(bus_if.arb_busy), 64'd0);
        bus_if.req_valid = '0;
        bus_if.req_flush = '0;
        bus_if.tbus_operation_done = 1'b1;
        settle();
        chk("idle_done_ignored", 64'(bus_if.resp_done), 64'd0);
        bus_if.tbus_operation_done = 1'b0;

        // Reset in the middle of a transaction.
        do_reset();
        bus_if.req_valid = 3'b001;
        tick();
        bus_if.tbus_index_ready = 1'b1;
        tick();
        bus_if.tbus_index_ready = 1'b0;
        bus_if.req_valid = '0;
        reset = 1'b1;
        tick();
        chk("mrst_busy", 64'(bus_if.arb_busy), 64'd0);
        chk("mrst_valid", 64'(bus_if.tbus_index_valid), 64'd0);
        reset = 1'b0;
        bus_if.tbus_operation_done = 1'b1;
        settle();
        chk("mrst_late_done", 64'(bus_if.resp_done), 64'd0);
        tick();
        bus_if.tbus_operation_done = 1'b0;
        settle();
        chk("mrst_idle", 64'(bus_if.arb_busy), 64'd0);

        // Randomized traffic against the round-robin model.
        do_reset();
        ptr = 0;
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        for (int it = 0; it < 80; it++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1'b1;
                    p_idx[i] = {$urandom, $urandom};
                    p_dat[i] = {$urandom, $urandom};
                    p_msk[i] = {$urandom, $urandom};
                    p_op[i]  = 2'($urandom_range(0, 1));
                    set_req(i, p_idx[i], p_dat[i], p_msk[i], p_op[i]);
                end
                bus_if.req_valid[i] = pend[i];
            end
            settle();
            chk("rnd_idle", 64'(bus_if.arb_busy), 64'd0);
            w = -1;
            for (int k = 0; k < NR; k++) begin
                c = (ptr + k) % NR;
                if (w < 0 && pend[c]) w = c;
            end
            tick();
            if (w < 0) continue;
            dly = $urandom_range(0, 3);
            for (int d = 0; d < dly; d++) begin
                settle();
                chk("rnd_hold_valid", 64'(bus_if.tbus_index_valid), 64'd1);
                chk("rnd_hold_index", bus_if.tbus_index, p_idx[w]);
                chk("rnd_hold_ready", 64'(bus_if.req_ready), 64'd0);
                tick();
            end
            sd = ($urandom_range(0, 3) == 0);
            rd = {$urandom, $urandom};
            bus_if.tbus_index_ready = 1'b1;
            bus_if.tbus_operation_done = sd;
            bus_if.tbus_read_data = rd;
            settle();
            chk("rnd_grant", 64'(bus_if.req_ready), 64'(1) << w);
            chk("rnd_index", bus_if.tbus_index, p_idx[w]);
            chk("rnd_wdata", bus_if.tbus_write_data, p_dat[w]);
            chk("rnd_mask", bus_if.tbus_write_mask, p_msk[w]);
            chk("rnd_op", 64'(bus_if.tbus_operation_type), 64'(p_op[w]));
            if (sd) chk("rnd_same_done", 64'(bus_if.resp_done), 64'(1) << w);
            tick();
            bus_if.tbus_index_ready = 1'b0;
            bus_if.tbus_operation_done = 1'b0;
            pend[w] = 1'b0;
            bus_if.req_valid[w] = 1'b0;
            if (sd) begin
                ptr = (w + 1) % NR;
                continue;
            end
            dly = $urandom_range(0, 2);
            for (int d = 0; d < dly; d++) begin
                settle();
                chk("rnd_wait_valid", 64'(bus_if.tbus_index_valid), 64'd0);
                chk("rnd_wait_busy", 64'(bus_if.arb_busy), 64'd1);
                tick();
            end
            fl = ($urandom_range(0, 4) == 0);
            rd = {$urandom, $urandom};
            bus_if.req_flush[w] = fl;
            bus_if.tbus_operation_done = 1'b1;
            bus_if.tbus_read_data = rd;
            settle();
            chk("rnd_done", 64'(bus_if.resp_done), fl ? 64'd0 : (64'(1) << w));
            chk("rnd_rdata", bus_if.resp_read_data, rd);
            tick();
            bus_if.tbus_operation_done = 1'b0;
            bus_if.req_flush = '0;
            ptr = (w + 1) % NR;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
